instr_fetch_unit: RTL and testbench

- Reads the combinational 24-bit instruction memory: drives Address, captures Instruction into a small queue, and presents fetched words to decode over a valid/ready handshake.
- Owns the PC and applies redirects (branch, jump, JR) from execute.
- Pre-decodes each word into format class and condition field so decode/issue need not re-slice it.

---
 rtl/isa_pkg.sv | 54 +++++
 rtl/fetch_queue.sv | 60 ++++++
 rtl/instr_fetch_unit.sv | 91 +++++++++
 tb/tb_instr_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA constants for the front end: widths, field positions, opcodes,
// format classes, the fetch-queue entry layout and the opcode pre-decoder.
package isa_pkg;

    localparam int IW = 24;
    localparam int AW = 24;

    localparam int COND_HI = 23;
    localparam int OP_HI   = 21;
    localparam int OP_LO   = 17;
    localparam int OPW     = OP_HI - OP_LO + 1;

    localparam logic [OPW-1:0] OP_AND  = 5'd0;
    localparam logic [OPW-1:0] OP_CAS  = 5'd1;
    localparam logic [OPW-1:0] OP_LWS  = 5'd2;
    localparam logic [OPW-1:0] OP_ADD  = 5'd3;
    localparam logic [OPW-1:0] OP_SUB  = 5'd4;
    localparam logic [OPW-1:0] OP_CMP  = 5'd5;
    localparam logic [OPW-1:0] OP_JR   = 5'd6;
    localparam logic [OPW-1:0] OP_ANDI = 5'd7;
    localparam logic [OPW-1:0] OP_ADDI = 5'd8;
    localparam logic [OPW-1:0] OP_LW   = 5'd9;
    localparam logic [OPW-1:0] OP_SW   = 5'd10;
    localparam logic [OPW-1:0] OP_BEQ  = 5'd11;
    localparam logic [OPW-1:0] OP_J    = 5'd12;
    localparam logic [OPW-1:0] OP_JAL  = 5'd13;
    localparam logic [OPW-1:0] OP_SHL  = 5'd14;

    typedef enum logic [1:0] {
        CLS_R   = 2'd0,
        CLS_I   = 2'd1,
        CLS_J   = 2'd2,
        CLS_ILL = 2'd3
    } insn_class_e;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
        insn_class_e   cls;
        logic [1:0]    cond;
    } fetch_entry_t;

    function automatic insn_class_e predecode(input logic [OPW-1:0] op);
        insn_class_e cls;
        case (op)
            OP_AND, OP_CAS, OP_LWS, OP_ADD, OP_SUB, OP_CMP, OP_JR: cls = CLS_R;
            OP_ANDI, OP_ADDI, OP_LW, OP_SW, OP_BEQ:                cls = CLS_I;
            OP_J, OP_JAL, OP_SHL:                                   cls = CLS_J;
            default:                                                cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of pre-decoded fetch entries; flush empties it in
// one cycle and wins over any push or pop issued in the same cycle.
module fetch_queue
    import isa_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    fetch_entry_t  mem [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign full  = (count == CW'(QDEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; an entry is only observable
    // once count says it was written, so clearing count is enough.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because QDEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational instruction memory,
// pre-decodes each word and queues it for decode behind a valid/ready handshake.
module instr_fetch_unit
    import isa_pkg::*;
#(
    parameter logic [AW-1:0] RESET_PC = 24'd0,
    parameter int            QDEPTH   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] Address,
    input  logic [IW-1:0] Instruction,
    input  logic          fetch_en,
    input  logic          redir_valid,
    input  logic [AW-1:0] redir_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_instr,
    output logic [AW-1:0] out_pc,
    output logic [AW-1:0] out_pc_plus1,
    output logic [1:0]    out_class,
    output logic [1:0]    out_cond,
    output logic          out_illegal
);

    logic [AW-1:0] pc;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    fetch_entry_t  new_entry;
    fetch_entry_t  head;

    assign Address = pc;

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign push      = fetch_en && !redir_valid && (!full || pop);

    assign new_entry = '{
        instr: Instruction,
        pc:    pc,
        cls:   predecode(Instruction[OP_HI:OP_LO]),
        cond:  Instruction[COND_HI -: 2]
    };

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else if (redir_valid)
            pc <= redir_pc;
        else if (push)
            pc <= pc + AW'(1);
    end

    fetch_queue #(
        .QDEPTH(QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redir_valid),
        .din   (new_entry),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Head fields are forced to zero while empty so stale storage never leaks.
    always_comb begin
        out_instr    = '0;
        out_pc       = '0;
        out_pc_plus1 = '0;
        out_class    = '0;
        out_cond     = '0;
        out_illegal  = 1'b0;
        if (!empty) begin
            out_instr    = head.instr;
            out_pc       = head.pc;
            out_pc_plus1 = head.pc + AW'(1);
            out_class    = head.cls;
            out_cond     = head.cond;
            out_illegal  = (head.cls == CLS_ILL);
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs change and outputs are sampled
// on the falling edge, against hand-computed values for a small memory image.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [23:0] Address;
    logic [23:0] Instruction;
    logic        fetch_en;
    logic        redir_valid;
    logic [23:0] redir_pc;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_instr;
    logic [23:0] out_pc;
    logic [23:0] out_pc_plus1;
    logic [1:0]  out_class;
    logic [1:0]  out_cond;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    logic [23:0] imem [64];
    assign Instruction = imem[Address[5:0]];

    instr_fetch_unit #(
        .RESET_PC(24'd0),
        .QDEPTH  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Address     (Address),
        .Instruction (Instruction),
        .fetch_en    (fetch_en),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pc_plus1(out_pc_plus1),
        .out_class   (out_class),
        .out_cond    (out_cond),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic head(input string tag, input logic v, input logic [23:0] pc,
                        input logic [23:0] addr);
        check({tag, ".valid"}, 24'(out_valid), 24'(v));
        check({tag, ".pc"}, out_pc, pc);
        check({tag, ".addr"}, Address, addr);
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            imem[i] = 24'h060000 | 24'(i);      // ADD, R-class
        imem[1]  = 24'h002980;                   // AND, R-class
        imem[32] = 24'h1E0000;                   // op 15 -> illegal
        imem[33] = 24'h560280;                   // BEQ, cond=01
        imem[34] = 24'h180000;                   // op 12 (J)
        imem[35] = 24'h0E0000;                   // op 7 (ANDI), first I
        imem[36] = 24'h0C0000;                   // op 6 (JR), last R

        rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
        redir_valid = 1'b0; redir_pc = '0;
        tick(); tick();
        check("rst.valid",   24'(out_valid), 24'd0);
        check("rst.addr",    Address, 24'd0);
        check("rst.instr",   out_instr, 24'd0);
        check("rst.pc",      out_pc, 24'd0);
        check("rst.pcp1",    out_pc_plus1, 24'd0);
        check("rst.class",   24'(out_class), 24'd0);
        check("rst.illegal", 24'(out_illegal), 24'd0);

        // Phase A: free-running fetch, one word per cycle.
        rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        check("a0.addr", Address, 24'd0);
        tick();
        head("a1", 1'b1, 24'd0, 24'd1);
        check("a1.instr", out_instr, 24'h060000);
        tick();
        head("a2", 1'b1, 24'd1, 24'd2);
        check("a2.instr", out_instr, 24'h002980);
        check("a2.class", 24'(out_class), 24'd0);
        check("a2.pcp1",  out_pc_plus1, 24'd2);
        tick();
        head("a3", 1'b1, 24'd2, 24'd3);
        out_ready = 1'b0;
        tick();
        head("a4", 1'b1, 24'd2, 24'd4);
        tick();
        head("a5", 1'b1, 24'd2, 24'd4);

        // Asynchronous reset between clock edges with two entries queued.
        #2 rst_n = 1'b0;
        #1;
        check("mrst.valid", 24'(out_valid), 24'd0);
        check("mrst.addr",  Address, 24'd0);
        check("mrst.pc",    out_pc, 24'd0);
        tick();

        // Phase B: stalled consumer fills the queue, then drains in order.
        rst_n = 1'b1;
        tick();
        head("b1", 1'b1, 24'd0, 24'd1);
        tick();
        head("b2", 1'b1, 24'd0, 24'd2);
        tick();
        head("b3", 1'b1, 24'd0, 24'd2);
        tick();
        head("b4", 1'b1, 24'd0, 24'd2);
        out_ready = 1'b1;
        tick();
        head("b5", 1'b1, 24'd1, 24'd3);
        check("b5.instr", out_instr, 24'h002980);
        tick();
        head("b6", 1'b1, 24'd2, 24'd4);
        tick();
        head("b7", 1'b1, 24'd3, 24'd5);
        out_ready = 1'b0;
        tick();
        head("b8", 1'b1, 24'd3, 24'd5);

        // Redirect while full: flush, then target arrives two edges later.
        redir_valid = 1'b1; redir_pc = 24'h000010;
        tick();
        head("r1", 1'b0, 24'd0, 24'h000010);
        redir_valid = 1'b0; out_ready = 1'b1;
        tick();
        head("r2", 1'b1, 24'h000010, 24'h000011);
        check("r2.instr", out_instr, 24'h060010);

        // PC wrap at the top of the address space.
        redir_valid = 1'b1; redir_pc = 24'hFFFFFF;
        tick();
        head("w1", 1'b0, 24'd0, 24'hFFFFFF);
        redir_valid = 1'b0;
        tick();
        head("w2", 1'b1, 24'hFFFFFF, 24'd0);
        check("w2.pcp1",  out_pc_plus1, 24'd0);
        check("w2.instr", out_instr, 24'h06003F);
        tick();
        head("w3", 1'b1, 24'd0, 24'd1);
        check("w3.pcp1", out_pc_plus1, 24'd1);

        // Pre-decode classes and class boundaries.
        redir_valid = 1'b1; redir_pc = 24'd32;
        tick();
        redir_valid = 1'b0;
        tick();
        head("d32", 1'b1, 24'd32, 24'd33);
        check("d32.class", 24'(out_class), 24'd3);
        check("d32.ill",   24'(out_illegal), 24'd1);
        tick();
        check("d33.class", 24'(out_class), 24'd1);
        check("d33.cond",  24'(out_cond), 24'd1);
        check("d33.ill",   24'(out_illegal), 24'd0);
        tick();
        check("d34.class", 24'(out_class), 24'd2);
        tick();
        check("d35.class", 24'(out_class), 24'd1);
        tick();
        head("d36", 1'b1, 24'd36, 24'd37);
        check("d36.class", 24'(out_class), 24'd0);

        // fetch_en low: queue drains, PC holds; a redirect still moves PC.
        fetch_en = 1'b0;
        tick();
        head("f1", 1'b0, 24'd0, 24'd37);
        tick();
        head("f2", 1'b0, 24'd0, 24'd37);
        redir_valid = 1'b1; redir_pc = 24'd8;
        tick();
        head("f3", 1'b0, 24'd0, 24'd8);
        redir_valid = 1'b0;
        tick();
        head("f4", 1'b0, 24'd0, 24'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
